// File: rtl/conv_layer_mem_resp_pkg.sv
// Shared constants for the CONV layer-memory responder: bank select codes,
// default bank depths, address widths and dump FSM state codes.
package conv_layer_mem_resp_pkg;

    localparam int ADDR_W    = 12;
    localparam int PHYS_W    = 14;
    localparam int NUM_BANKS = 5;

    localparam int L0_DEPTH_DEF = 4096;
    localparam int L1_DEPTH_DEF = 1024;
    localparam int L2_DEPTH_DEF = 2048;

    localparam logic [2:0] CSEL_L0K0 = 3'b001;
    localparam logic [2:0] CSEL_L0K1 = 3'b010;
    localparam logic [2:0] CSEL_L1K0 = 3'b011;
    localparam logic [2:0] CSEL_L1K1 = 3'b100;
    localparam logic [2:0] CSEL_L2   = 3'b101;

    typedef logic [1:0] dump_state_t;
    localparam dump_state_t ST_IDLE    = 2'd0;
    localparam dump_state_t ST_FETCH   = 2'd1;
    localparam dump_state_t ST_PRESENT = 2'd2;

    function automatic logic sel_legal(input logic [2:0] sel);
        return (sel >= CSEL_L0K0) && (sel <= CSEL_L2);
    endfunction

endpackage

// File: rtl/conv_layer_mem_resp_bank_map.sv
// Combinational bank decoder: bank select + in-bank address -> physical word
// address in the unified array, bank index, bank depth and a legality flag.
module conv_mem_bank_map
    import conv_layer_mem_resp_pkg::*;
#(
    parameter int L0_DEPTH = L0_DEPTH_DEF,
    parameter int L1_DEPTH = L1_DEPTH_DEF,
    parameter int L2_DEPTH = L2_DEPTH_DEF
) (
    input  logic [2:0]        sel_i,
    input  logic [ADDR_W-1:0] addr_i,
    output logic [PHYS_W-1:0] phys_o,
    output logic [2:0]        bank_o,
    output logic [PHYS_W-1:0] depth_o,
    output logic              legal_o
);

    localparam logic [PHYS_W-1:0] D0 = PHYS_W'(L0_DEPTH);
    localparam logic [PHYS_W-1:0] D1 = PHYS_W'(L1_DEPTH);
    localparam logic [PHYS_W-1:0] D2 = PHYS_W'(L2_DEPTH);
    localparam logic [PHYS_W-1:0] B1 = PHYS_W'(L0_DEPTH);
    localparam logic [PHYS_W-1:0] B2 = PHYS_W'(2 * L0_DEPTH);
    localparam logic [PHYS_W-1:0] B3 = PHYS_W'(2 * L0_DEPTH + L1_DEPTH);
    localparam logic [PHYS_W-1:0] B4 = PHYS_W'(2 * L0_DEPTH + 2 * L1_DEPTH);

    logic [PHYS_W-1:0] base;
    logic [PHYS_W-1:0] addr_ext;

    always_comb begin
        base     = '0;
        depth_o  = '0;
        bank_o   = 3'd0;
        addr_ext = {{(PHYS_W - ADDR_W){1'b0}}, addr_i};
        case (sel_i)
            CSEL_L0K0: begin base = '0; depth_o = D0; bank_o = 3'd0; end
            CSEL_L0K1: begin base = B1; depth_o = D0; bank_o = 3'd1; end
            CSEL_L1K0: begin base = B2; depth_o = D1; bank_o = 3'd2; end
            CSEL_L1K1: begin base = B3; depth_o = D1; bank_o = 3'd3; end
            CSEL_L2:   begin base = B4; depth_o = D2; bank_o = 3'd4; end
            default:   begin base = '0; depth_o = '0; bank_o = 3'd0; end
        endcase
        // An illegal select has depth 0, so the range test rejects it too.
        legal_o = sel_legal(sel_i) && (addr_ext < depth_o);
        phys_o  = base + addr_ext;
    end

endmodule

// File: rtl/conv_layer_mem_resp.sv
// CONV layer-memory responder: five result banks in one 1W1R array, CONV
// read/write service, per-bank write counters and a host dump stream.
module conv_layer_mem_resp
    import conv_layer_mem_resp_pkg::*;
#(
    parameter int DW       = 20,
    parameter int L0_DEPTH = L0_DEPTH_DEF,
    parameter int L1_DEPTH = L1_DEPTH_DEF,
    parameter int L2_DEPTH = L2_DEPTH_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cwr,
    input  logic [ADDR_W-1:0] caddr_wr,
    input  logic [DW-1:0]     cdata_wr,
    input  logic              crd,
    input  logic [ADDR_W-1:0] caddr_rd,
    input  logic [2:0]        csel,
    output logic [DW-1:0]     cdata_rd,
    output logic [4:0]        bank_full,
    output logic              addr_err,
    input  logic              dump_req,
    input  logic [2:0]        dump_sel,
    output logic              dump_valid,
    output logic [DW-1:0]     dump_data,
    output logic              dump_last,
    input  logic              dump_ready
);

    localparam int TOTAL = 2 * L0_DEPTH + 2 * L1_DEPTH + L2_DEPTH;
    localparam logic [PHYS_W-1:0] DEPTH_TAB [NUM_BANKS] = '{
        PHYS_W'(L0_DEPTH), PHYS_W'(L0_DEPTH), PHYS_W'(L1_DEPTH),
        PHYS_W'(L1_DEPTH), PHYS_W'(L2_DEPTH)
    };

    logic [PHYS_W-1:0] wr_phys, crd_phys, dump_phys, rd_phys;
    logic [PHYS_W-1:0] wr_depth, rd_depth, dump_depth;
    logic [2:0]        wr_bank, rd_bank, dump_bank;
    logic              wr_legal, rd_legal, dump_legal;
    logic              wr_en;
    logic [DW-1:0]     rd_word;
    logic              dump_last_c;

    logic [DW-1:0]     mem_q [TOTAL];

    logic [DW-1:0]     cdata_rd_q, cdata_rd_d;
    logic              addr_err_q, addr_err_d;
    logic [PHYS_W-1:0] cnt_q [NUM_BANKS];
    logic [PHYS_W-1:0] cnt_d [NUM_BANKS];
    logic [4:0]        full_q, full_d;

    dump_state_t       state_q, state_d;
    logic [ADDR_W-1:0] daddr_q, daddr_d;
    logic [2:0]        dsel_q, dsel_d;
    logic              dvalid_q, dvalid_d;
    logic              dlast_q, dlast_d;
    logic [DW-1:0]     ddata_q, ddata_d;
    logic              dump_err;

    logic              unused_map;
    assign unused_map = ^{rd_bank, rd_depth, dump_bank, dump_legal, wr_depth};

    conv_mem_bank_map #(.L0_DEPTH(L0_DEPTH), .L1_DEPTH(L1_DEPTH), .L2_DEPTH(L2_DEPTH)) u_map_wr (
        .sel_i(csel), .addr_i(caddr_wr), .phys_o(wr_phys), .bank_o(wr_bank),
        .depth_o(wr_depth), .legal_o(wr_legal)
    );

    conv_mem_bank_map #(.L0_DEPTH(L0_DEPTH), .L1_DEPTH(L1_DEPTH), .L2_DEPTH(L2_DEPTH)) u_map_rd (
        .sel_i(csel), .addr_i(caddr_rd), .phys_o(crd_phys), .bank_o(rd_bank),
        .depth_o(rd_depth), .legal_o(rd_legal)
    );

    conv_mem_bank_map #(.L0_DEPTH(L0_DEPTH), .L1_DEPTH(L1_DEPTH), .L2_DEPTH(L2_DEPTH)) u_map_dump (
        .sel_i(dsel_q), .addr_i(daddr_q), .phys_o(dump_phys), .bank_o(dump_bank),
        .depth_o(dump_depth), .legal_o(dump_legal)
    );

    assign wr_en = cwr & wr_legal;

    // Single read port: CONV always wins it, the dump only reads when crd is low.
    assign rd_phys = crd ? crd_phys : dump_phys;
    assign rd_word = (wr_en && (wr_phys == rd_phys)) ? cdata_wr : mem_q[rd_phys];

    assign dump_last_c = ({{(PHYS_W - ADDR_W){1'b0}}, daddr_q} == (dump_depth - PHYS_W'(1)));

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_phys] <= cdata_wr;
        end
    end

    always_comb begin
        cdata_rd_d = cdata_rd_q;
        if (crd && rd_legal) begin
            cdata_rd_d = rd_word;
        end
        addr_err_d = addr_err_q | (cwr & ~wr_legal) | (crd & ~rd_legal) | dump_err;
    end

    always_comb begin
        for (int i = 0; i < NUM_BANKS; i++) begin
            cnt_d[i] = cnt_q[i];
            if (wr_en && (wr_bank == 3'(i)) && (cnt_q[i] < DEPTH_TAB[i])) begin
                cnt_d[i] = cnt_q[i] + PHYS_W'(1);
            end
            full_d[i] = (cnt_d[i] >= DEPTH_TAB[i]);
        end
    end

    always_comb begin
        state_d  = state_q;
        daddr_d  = daddr_q;
        dsel_d   = dsel_q;
        dvalid_d = dvalid_q;
        dlast_d  = dlast_q;
        ddata_d  = ddata_q;
        dump_err = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (dump_req) begin
                    if (sel_legal(dump_sel)) begin
                        state_d = ST_FETCH;
                        dsel_d  = dump_sel;
                        daddr_d = '0;
                    end else begin
                        dump_err = 1'b1;
                    end
                end
            end
            ST_FETCH: begin
                if (!crd) begin
                    state_d  = ST_PRESENT;
                    dvalid_d = 1'b1;
                    ddata_d  = rd_word;
                    dlast_d  = dump_last_c;
                end
            end
            ST_PRESENT: begin
                if (dump_ready) begin
                    dvalid_d = 1'b0;
                    dlast_d  = 1'b0;
                    if (dlast_q) begin
                        state_d = ST_IDLE;
                    end else begin
                        daddr_d = daddr_q + ADDR_W'(1);
                        state_d = ST_FETCH;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cdata_rd_q <= '0;
            addr_err_q <= 1'b0;
            full_q     <= '0;
            for (int i = 0; i < NUM_BANKS; i++) begin
                cnt_q[i] <= '0;
            end
            state_q    <= ST_IDLE;
            daddr_q    <= '0;
            dsel_q     <= '0;
            dvalid_q   <= 1'b0;
            dlast_q    <= 1'b0;
            ddata_q    <= '0;
        end else begin
            cdata_rd_q <= cdata_rd_d;
            addr_err_q <= addr_err_d;
            full_q     <= full_d;
            for (int i = 0; i < NUM_BANKS; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            state_q    <= state_d;
            daddr_q    <= daddr_d;
            dsel_q     <= dsel_d;
            dvalid_q   <= dvalid_d;
            dlast_q    <= dlast_d;
            ddata_q    <= ddata_d;
        end
    end

    assign cdata_rd   = cdata_rd_q;
    assign addr_err   = addr_err_q;
    assign bank_full  = full_q;
    assign dump_valid = dvalid_q;
    assign dump_last  = dlast_q;
    assign dump_data  = ddata_q;

endmodule

// File: tb/tb_conv_layer_mem_resp.sv
// Bench for conv_layer_mem_resp: directed CONV/dump traffic against a
// word-array model of the five banks, compared on every falling edge.
module tb_conv_layer_mem_resp;

    localparam int DW = 20;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          cwr = 1'b0;
    logic [11:0]   caddr_wr = '0;
    logic [DW-1:0] cdata_wr = '0;
    logic          crd = 1'b0;
    logic [11:0]   caddr_rd = '0;
    logic [2:0]    csel = '0;
    logic [DW-1:0] cdata_rd;
    logic [4:0]    bank_full;
    logic          addr_err;
    logic          dump_req = 1'b0;
    logic [2:0]    dump_sel = '0;
    logic          dump_valid;
    logic [DW-1:0] dump_data;
    logic          dump_last;
    logic          dump_ready = 1'b0;

    always #5 clk = ~clk;

    conv_layer_mem_resp #(.DW(DW)) dut (
        .clk(clk), .reset(reset),
        .cwr(cwr), .caddr_wr(caddr_wr), .cdata_wr(cdata_wr),
        .crd(crd), .caddr_rd(caddr_rd), .csel(csel), .cdata_rd(cdata_rd),
        .bank_full(bank_full), .addr_err(addr_err),
        .dump_req(dump_req), .dump_sel(dump_sel), .dump_valid(dump_valid),
        .dump_data(dump_data), .dump_last(dump_last), .dump_ready(dump_ready)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Model state: bank layout tables and the expected contents/outputs.
    int            base_t [5]  = '{0, 4096, 8192, 9216, 10240};
    int            depth_t [5] = '{4096, 4096, 1024, 1024, 2048};
    logic [DW-1:0] m_mem [12288];
    int            m_cnt [5]   = '{0, 0, 0, 0, 0};
    logic [DW-1:0] m_rd  = '0;
    logic          m_err = 1'b0;
    bit            m_dact = 1'b0;
    int            m_dbank = 0;
    int            m_didx = 0;
    int            dump_words = 0;
    int            dump_lasts = 0;
    bit            t_wl, t_rl;
    int            t_wp, t_rp, t_wb;

    function automatic int bank_of(input logic [2:0] s);
        return (s >= 3'd1 && s <= 3'd5) ? int'(s) - 1 : -1;
    endfunction

    function automatic bit legal(input logic [2:0] s, input logic [11:0] a);
        int b;
        b = bank_of(s);
        return (b >= 0) && (int'(a) < depth_t[b]);
    endfunction

    function automatic logic [4:0] exp_full();
        logic [4:0] f;
        for (int i = 0; i < 5; i++) f[i] = (m_cnt[i] >= depth_t[i]);
        return f;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h at %0t", nm, act, req, $time);
        end
    endtask

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_rd   = '0;
            m_err  = 1'b0;
            m_dact = 1'b0;
            for (int i = 0; i < 5; i++) m_cnt[i] = 0;
        end else begin
            t_wl = cwr && legal(csel, caddr_wr);
            t_rl = crd && legal(csel, caddr_rd);
            if (cwr && !t_wl) m_err = 1'b1;
            if (crd && !t_rl) m_err = 1'b1;
            t_wb = bank_of(csel);
            t_wp = (t_wb >= 0) ? base_t[t_wb] + int'(caddr_wr) : 0;
            t_rp = (t_wb >= 0) ? base_t[t_wb] + int'(caddr_rd) : 0;
            if (t_rl) m_rd = (t_wl && t_wp == t_rp) ? cdata_wr : m_mem[t_rp];
            if (t_wl) begin
                m_mem[t_wp] = cdata_wr;
                if (m_cnt[t_wb] < depth_t[t_wb]) m_cnt[t_wb]++;
            end
            if (m_dact && dump_valid && dump_ready) begin
                dump_words++;
                if (dump_last) dump_lasts++;
                if (m_didx == depth_t[m_dbank] - 1) m_dact = 1'b0;
                m_didx++;
            end else if (!m_dact && dump_req) begin
                if (bank_of(dump_sel) >= 0) begin
                    m_dact  = 1'b1;
                    m_dbank = bank_of(dump_sel);
                    m_didx  = 0;
                end else begin
                    m_err = 1'b1;
                end
            end
        end
    end

    always @(negedge clk) begin
        chk("cdata_rd", 32'(cdata_rd), 32'(m_rd));
        chk("bank_full", 32'(bank_full), 32'(exp_full()));
        chk("addr_err", 32'(addr_err), 32'(m_err));
        if (!m_dact) begin
            chk("dump_valid_idle", 32'(dump_valid), 32'd0);
        end else if (dump_valid) begin
            chk("dump_data", 32'(dump_data), 32'(m_mem[base_t[m_dbank] + m_didx]));
            chk("dump_last", 32'(dump_last), 32'(m_didx == depth_t[m_dbank] - 1));
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [2:0] s, input logic [11:0] a, input logic [DW-1:0] d);
        csel = s; caddr_wr = a; cdata_wr = d; cwr = 1'b1;
        cyc();
        cwr = 1'b0;
    endtask

    task automatic rd(input logic [2:0] s, input logic [11:0] a);
        csel = s; caddr_rd = a; crd = 1'b1;
        cyc();
        crd = 1'b0;
    endtask

    task automatic pulse_reset();
        reset = 1'b0;
        cyc();
        reset = 1'b1;
        cyc();
    endtask

    initial begin
        repeat (3) cyc();
        chk("rst_cdata_rd", 32'(cdata_rd), 32'd0);
        chk("rst_bank_full", 32'(bank_full), 32'd0);
        chk("rst_addr_err", 32'(addr_err), 32'd0);
        chk("rst_dump_valid", 32'(dump_valid), 32'd0);
        reset = 1'b1;
        cyc();

        // Write then read back.
        wr(3'b001, 12'd5, 20'h12345);
        rd(3'b001, 12'd5);
        chk("t1_readback", 32'(cdata_rd), 32'h12345);
        cyc();
        chk("t1_held", 32'(cdata_rd), 32'h12345);

        // Same-cycle write and read of one word forwards the new data.
        csel = 3'b101; caddr_wr = 12'd2047; caddr_rd = 12'd2047; cdata_wr = 20'hABCDE;
        cwr = 1'b1; crd = 1'b1;
        cyc();
        cwr = 1'b0; crd = 1'b0;
        chk("t2_forward", 32'(cdata_rd), 32'hABCDE);
        csel = 3'b101; caddr_wr = 12'd100; caddr_rd = 12'd2047; cdata_wr = 20'h0F0F0;
        cwr = 1'b1; crd = 1'b1;
        cyc();
        cwr = 1'b0; crd = 1'b0;
        chk("t2_indep_rd", 32'(cdata_rd), 32'hABCDE);
        rd(3'b101, 12'd100);
        chk("t2_indep_wr", 32'(cdata_rd), 32'h0F0F0);
        chk("t2_no_err", 32'(addr_err), 32'd0);

        // Out-of-range address and illegal select.
        wr(3'b011, 12'd1024, 20'h11111);
        chk("t3_err_range", 32'(addr_err), 32'd1);
        rd(3'b001, 12'd5);
        chk("t3_intact", 32'(cdata_rd), 32'h12345);
        pulse_reset();
        chk("t3_err_cleared", 32'(addr_err), 32'd0);
        wr(3'b111, 12'd0, 20'h22222);
        chk("t3_err_sel", 32'(addr_err), 32'd1);
        rd(3'b101, 12'd2047);
        chk("t3_intact_l2", 32'(cdata_rd), 32'hABCDE);
        rd(3'b110, 12'd0);
        chk("t3_illegal_rd_hold", 32'(cdata_rd), 32'hABCDE);
        pulse_reset();

        // Fill L0k1 to its depth, then one more write.
        for (int i = 0; i < 4096; i++) begin
            wr(3'b010, 12'(i), 20'((i * 3) ^ 32'h5A5A5));
            if (i == 4094) chk("t4_not_full", 32'(bank_full), 32'd0);
        end
        chk("t4_full", 32'(bank_full), 32'b00010);
        wr(3'b010, 12'd0, 20'h77777);
        chk("t4_saturate", 32'(bank_full), 32'b00010);
        chk("t4_no_err", 32'(addr_err), 32'd0);

        // Fill L1k1 and stream it out under random back-pressure.
        for (int i = 0; i < 1024; i++) wr(3'b100, 12'(i), 20'(i ^ 32'h155));
        chk("t5_full", 32'(bank_full), 32'b01010);
        dump_sel = 3'b100; dump_req = 1'b1;
        cyc();
        dump_req = 1'b0;
        for (int k = 0; k < 6000 && !(dump_words == 1024 && !m_dact); k++) begin
            dump_ready = 1'($urandom_range(0, 1));
            cyc();
        end
        dump_ready = 1'b0;
        chk("t5_words", 32'(dump_words), 32'd1024);
        chk("t5_lasts", 32'(dump_lasts), 32'd1);
        cyc();
        chk("t5_idle", 32'(dump_valid), 32'd0);
        dump_sel = 3'b110; dump_req = 1'b1;
        cyc();
        dump_req = 1'b0;
        chk("t5_bad_sel_err", 32'(addr_err), 32'd1);
        cyc();
        chk("t5_bad_sel_idle", 32'(dump_valid), 32'd0);
        pulse_reset();

        // CONV reads stall the dump fetch.
        dump_sel = 3'b100; dump_req = 1'b1;
        cyc();
        dump_req = 1'b0;
        crd = 1'b1; csel = 3'b001; caddr_rd = 12'd5;
        for (int k = 0; k < 3; k++) begin
            cyc();
            chk("t6_stall", 32'(dump_valid), 32'd0);
        end
        crd = 1'b0;
        cyc();
        chk("t6_present", 32'(dump_valid), 32'd1);
        chk("t6_word0", 32'(dump_data), 32'h00155);
        chk("t6_conv_rd", 32'(cdata_rd), 32'h12345);
        dump_ready = 1'b1;
        dump_sel = 3'b001; dump_req = 1'b1;
        repeat (5) cyc();
        dump_req = 1'b0;
        for (int k = 0; k < 4 && !dump_valid; k++) cyc();
        chk("t6_valid_before_rst", 32'(dump_valid), 32'd1);
        #2 reset = 1'b0;
        #1 chk("t6_rst_async", 32'(dump_valid), 32'd0);
        cyc();
        reset = 1'b1;
        dump_ready = 1'b0;
        cyc();
        dump_sel = 3'b100; dump_req = 1'b1;
        cyc();
        dump_req = 1'b0;
        cyc();
        chk("t6_restart_valid", 32'(dump_valid), 32'd1);
        chk("t6_restart_word0", 32'(dump_data), 32'h00155);
        chk("t6_restart_last", 32'(dump_last), 32'd0);
        repeat (3) cyc();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
